// File: rtl/add_pkg.sv
// add_pkg: shared width default and accumulator sequencing states for the add stage and its front-end
package add_pkg;
  localparam int ADD_DATA_WIDTH = 32;
  typedef enum logic [2:0] {IDLE, FIRST, NEXT, ISSUE, WAIT, DONE} accum_state_t;
endpackage

// File: rtl/add_accum_ctrl_if.sv
// add_accum_ctrl_if: job control, input stream, add-stage operands and result stream of the accumulator front-end
interface add_accum_ctrl_if #(
  parameter int DATA_WIDTH  = add_pkg::ADD_DATA_WIDTH,
  parameter int COUNT_WIDTH = 8
);
  logic                   start;
  logic [COUNT_WIDTH-1:0] cfg_len;
  logic                   busy;
  logic [DATA_WIDTH-1:0]  in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   add_start;
  logic [DATA_WIDTH-1:0]  add_a;
  logic [DATA_WIDTH-1:0]  add_b;
  logic [DATA_WIDTH-1:0]  add_sum;
  logic                   add_complete;
  logic [DATA_WIDTH-1:0]  out_sum;
  logic                   out_ovf;
  logic                   out_valid;
  logic                   out_ready;
  modport ctrl (
    input  start, cfg_len, in_data, in_valid, add_sum, add_complete, out_ready,
    output busy, in_ready, add_start, add_a, add_b, out_sum, out_ovf, out_valid
  );
  modport env (
    output start, cfg_len, in_data, in_valid, add_sum, add_complete, out_ready,
    input  busy, in_ready, add_start, add_a, add_b, out_sum, out_ovf, out_valid
  );
endinterface

// File: rtl/add.sv
// add: two-stage pipelined adder; complete pulses two cycles after start, carry is dropped
module add import add_pkg::*; #(
  parameter int DATA_WIDTH = ADD_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] addend1,
  input  logic [DATA_WIDTH-1:0] addend2,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  complete
);
  logic [DATA_WIDTH-1:0] s1_d, s1_q, s2_q;
  logic                  v1_q, v2_q;
  always_comb s1_d = addend1 + addend2;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q <= '0;
      s2_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s1_q;
      v1_q <= start;
      v2_q <= v1_q;
    end
  end
  assign sum      = s2_q;
  assign complete = v2_q;
endmodule

// File: rtl/add_accum_ctrl.sv
// add_accum_ctrl: folds a job of stream words into a running sum through the external add stage,
// tracking unsigned wrap locally since add drops its carry
module add_accum_ctrl import add_pkg::*; #(
  parameter int DATA_WIDTH  = ADD_DATA_WIDTH,
  parameter int COUNT_WIDTH = 8,
  parameter int MIN_ADD_LAT = 2
) (
  input logic            clock,
  input logic            reset,
  add_accum_ctrl_if.ctrl bus
);
  localparam int WW = (MIN_ADD_LAT > 2) ? $clog2(MIN_ADD_LAT) : 1;
  localparam logic [WW-1:0] LAT_M1 = WW'(MIN_ADD_LAT - 1);
  accum_state_t           state_d, state_q;
  logic [DATA_WIDTH-1:0]  acc_d, acc_q, op_d, op_q;
  logic [COUNT_WIDTH-1:0] rem_d, rem_q;
  logic                   ovf_d, ovf_q;
  logic [WW-1:0]          wait_d, wait_q;
  logic                   done_ok;
  // complete is trusted only once the add stage could legally have finished
  assign done_ok = bus.add_complete && (wait_q == LAT_M1);
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: if (bus.start) begin
        rem_d   = bus.cfg_len;
        ovf_d   = 1'b0;
        acc_d   = '0;
        state_d = (bus.cfg_len == '0) ? DONE : FIRST;
      end
      FIRST: if (bus.in_valid) begin
        acc_d   = bus.in_data;
        rem_d   = rem_q - 1'b1;
        state_d = (rem_q == COUNT_WIDTH'(1)) ? DONE : NEXT;
      end
      NEXT: if (bus.in_valid) begin
        op_d    = bus.in_data;
        rem_d   = rem_q - 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        wait_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wait_d = (wait_q == LAT_M1) ? wait_q : wait_q + 1'b1;
        if (done_ok) begin
          acc_d   = bus.add_sum;
          ovf_d   = ovf_q | (bus.add_sum < acc_q);
          state_d = (rem_q == '0) ? DONE : NEXT;
        end
      end
      DONE: state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      op_q    <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      wait_q  <= wait_d;
    end
  end
  assign bus.busy      = state_q != IDLE;
  assign bus.in_ready  = (state_q == FIRST) || (state_q == NEXT);
  assign bus.add_start = state_q == ISSUE;
  assign bus.add_a     = acc_q;
  assign bus.add_b     = op_q;
  assign bus.out_sum   = acc_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_valid = state_q == DONE;
endmodule

// File: tb/tb_add_accum_ctrl.sv
// tb_add_accum_ctrl: table vectors, hand sequences and random jobs against an arithmetic reference of the job sum
module tb_add_accum_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cycle = 0;
  int   st_cyc[$];
  int   n_inrdy = 0;
  logic [31:0] jw[8];

  add_accum_ctrl_if #(.DATA_WIDTH(32), .COUNT_WIDTH(8)) bus ();

  add_accum_ctrl #(.DATA_WIDTH(32), .COUNT_WIDTH(8), .MIN_ADD_LAT(2)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  add #(.DATA_WIDTH(32)) u_add (
    .clock   (clock),
    .reset   (reset),
    .start   (bus.add_start),
    .addend1 (bus.add_a),
    .addend2 (bus.add_b),
    .sum     (bus.add_sum),
    .complete(bus.add_complete)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;
  always @(negedge clock) begin
    if (bus.add_start) st_cyc.push_back(cycle);
    if (bus.in_ready) n_inrdy <= n_inrdy + 1;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference: the job result is the plain modular sum; overflow means some running total carried out
  task automatic model(input int len, output logic [31:0] s, output logic o);
    logic [32:0] wide;
    s = '0;
    o = 1'b0;
    for (int i = 0; i < len; i++) begin
      wide = {1'b0, s} + {1'b0, jw[i]};
      s = wide[31:0];
      o = o | wide[32];
    end
  endtask

  task automatic run_job(input int len, input logic [31:0] es, input logic eo, input int gap_pct,
                         input int stall, input bit poke, input string tag);
    int   idx, cyc, s0, r0;
    logic hs;
    idx = 0;
    cyc = 0;
    s0 = st_cyc.size();
    r0 = n_inrdy;
    bus.cfg_len = 8'(len);
    bus.start = 1'b1;
    bus.out_ready = (stall == 0);
    tick;
    bus.start = 1'b0;
    chk({tag, " busy_after_start"}, bus.busy, 1);
    if (len == 0) chk({tag, " valid_after_start"}, bus.out_valid, 1);
    else chk({tag, " in_ready_after_start"}, bus.in_ready, 1);
    while (!bus.out_valid && cyc < 500) begin
      bus.in_valid = (idx < len) && ($urandom_range(99) >= gap_pct);
      bus.in_data = bus.in_valid ? jw[idx] : $urandom;
      bus.start = poke && (cyc == 3);
      bus.cfg_len = bus.start ? 8'd7 : 8'(len);
      hs = bus.in_valid && bus.in_ready;
      tick;
      if (hs) idx++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.start = 1'b0;
    chk({tag, " out_valid_reached"}, bus.out_valid, 1);
    chk({tag, " words_consumed"}, idx, len);
    chk({tag, " out_sum"}, bus.out_sum, es);
    chk({tag, " out_ovf"}, bus.out_ovf, eo);
    chk({tag, " add_start_count"}, st_cyc.size() - s0, (len > 1) ? len - 1 : 0);
    if (len == 0) chk({tag, " no_in_ready"}, n_inrdy - r0, 0);
    if (gap_pct == 0) begin
      chk({tag, " latency"}, cyc, (len == 0) ? 0 : 4 * len - 3);
      for (int i = s0 + 1; i < st_cyc.size(); i++)
        chk({tag, " add_start_spacing"}, st_cyc[i] - st_cyc[i-1], 4);
    end
    for (int i = 0; i < stall; i++) begin
      tick;
      chk({tag, " valid_held"}, bus.out_valid, 1);
      chk({tag, " sum_stable"}, bus.out_sum, es);
    end
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    chk({tag, " busy_after_accept"}, bus.busy, 0);
    chk({tag, " valid_after_accept"}, bus.out_valid, 0);
    chk({tag, " sum_held_after_accept"}, bus.out_sum, es);
  endtask

  typedef struct {
    int              len;
    logic [3:0][31:0] w;
    logic [31:0]     sum;
    logic            ovf;
    int              gap;
    int              stall;
    bit              poke;
  } vec_t;

  initial begin : main
    vec_t v[6];
    logic [31:0] ms;
    logic        mo;
    int          s0, len;
    v[0] = '{0, {32'd0, 32'd0, 32'd0, 32'd0}, 32'd0, 1'b0, 0, 0, 1'b0};
    v[1] = '{1, {32'd0, 32'd0, 32'd0, 32'h7}, 32'd7, 1'b0, 0, 0, 1'b0};
    v[2] = '{4, {32'd4, 32'd3, 32'd2, 32'd1}, 32'd10, 1'b0, 0, 0, 1'b0};
    v[3] = '{3, {32'd0, 32'h1, 32'h2, 32'hFFFF_FFFF}, 32'h2, 1'b1, 0, 0, 1'b0};
    v[4] = '{4, {32'd4, 32'd3, 32'd2, 32'd1}, 32'd10, 1'b0, 50, 5, 1'b1};
    v[5] = '{2, {32'd0, 32'd0, 32'h8000_0000, 32'h8000_0000}, 32'd0, 1'b1, 0, 2, 1'b0};
    bus.start = 1'b0;
    bus.cfg_len = '0;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) tick;
    chk("reset busy", bus.busy, 0);
    chk("reset in_ready", bus.in_ready, 0);
    chk("reset add_start", bus.add_start, 0);
    chk("reset add_a", bus.add_a, 0);
    chk("reset add_b", bus.add_b, 0);
    chk("reset out_sum", bus.out_sum, 0);
    chk("reset out_ovf", bus.out_ovf, 0);
    chk("reset out_valid", bus.out_valid, 0);
    reset = 1'b1;
    tick;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 4; i++) jw[i] = v[k].w[i];
      run_job(v[k].len, v[k].sum, v[k].ovf, v[k].gap, v[k].stall, v[k].poke, $sformatf("vec%0d", k));
    end
    // abort in WAIT: start a 3-word job, reset once the first add is in flight
    jw[0] = 32'd100;
    jw[1] = 32'd200;
    bus.cfg_len = 8'd3;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = jw[0];
    tick;
    bus.in_data = jw[1];
    tick;
    for (int i = 0; i < 20 && !bus.add_start; i++) tick;
    chk("abort add_start_seen", bus.add_start, 1);
    tick;
    reset = 1'b0;
    #1;
    chk("abort busy", bus.busy, 0);
    chk("abort add_a", bus.add_a, 0);
    chk("abort add_b", bus.add_b, 0);
    chk("abort out_sum", bus.out_sum, 0);
    tick;
    chk("abort out_valid", bus.out_valid, 0);
    chk("abort out_ovf", bus.out_ovf, 0);
    chk("abort in_ready", bus.in_ready, 0);
    reset = 1'b1;
    s0 = st_cyc.size();
    repeat (6) tick;
    chk("abort no_add_start", st_cyc.size() - s0, 0);
    chk("abort idle", bus.busy, 0);
    bus.in_valid = 1'b0;
    jw[0] = 32'd5;
    jw[1] = 32'd6;
    run_job(2, 32'd11, 1'b0, 0, 0, 1'b0, "post_reset");
    for (int k = 0; k < 8; k++) begin
      len = $urandom_range(0, 8);
      for (int i = 0; i < 8; i++)
        jw[i] = ($urandom_range(2) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15)) : $urandom;
      model(len, ms, mo);
      run_job(len, ms, mo, (k % 2) ? 40 : 0, $urandom_range(0, 5), (k == 3) && (len >= 3),
              $sformatf("rnd%0d", k));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
